// File: rtl/ramp_gen_pkg.sv
// ramp_gen shared constants and the amplitude saturation helper.
// Imported by the lane, interface and top-level files.
package ramp_gen_pkg;

  localparam int NUM_LANES = 16;
  localparam int SAMPLE_W  = 16;
  localparam int PHASE_W   = 32;
  localparam int AMP_FRAC  = 16;
  localparam int DATA_W    = NUM_LANES * SAMPLE_W;

  // Gain is Q0.16; anything at or above 1.0 clamps to 0xFFFF.
  function automatic logic [SAMPLE_W-1:0] sat16(
    input logic [PHASE_W-1:0] amp
  );
    if (amp[PHASE_W-1:SAMPLE_W] != '0) begin
      return '1;
    end
    return amp[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/ramp_gen_if.sv
// AXI4-Stream bundle for the ramp output (TDATA/TSTRB/TLAST/TVALID/TREADY).
// master drives data and valid, slave drives ready.
interface ramp_gen_if;
  import ramp_gen_pkg::*;

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tstrb, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/ramp_lane.sv
// One ramp lane: phase_i (32b) and amp_i (16b gain) -> sample_o (16b signed).
// Purely combinational; sample = (phase[31:16] * amp) >>> 16.
module ramp_lane
  import ramp_gen_pkg::*;
(
  input  logic [PHASE_W-1:0]  phase_i,
  input  logic [SAMPLE_W-1:0] amp_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  logic signed [SAMPLE_W-1:0] s;
  logic signed [SAMPLE_W:0]   a;
  logic signed [2*SAMPLE_W:0] prod;
  logic                       unused_bits;

  assign s    = phase_i[PHASE_W-1:PHASE_W-SAMPLE_W];
  // Zero-extend the gain so the multiply stays signed.
  assign a    = {1'b0, amp_i};
  assign prod = s * a;

  // Taking bits [31:16] is the floor shift then truncation.
  assign sample_o = prod[AMP_FRAC+SAMPLE_W-1:AMP_FRAC];

  assign unused_bits = ^{phase_i[PHASE_W-SAMPLE_W-1:0],
                         prod[2*SAMPLE_W],
                         prod[AMP_FRAC-1:0]};

endmodule

// File: rtl/ramp_gen.sv
// Sawtooth source: 16 samples/beat on an AXI4-Stream master (m_axis).
// Ports: M_AXIS_ACLK, M_AXIS_ARESETN (sync, low), frequency, amplitude.
module ramp_gen
  import ramp_gen_pkg::*;
(
  input  logic               M_AXIS_ACLK,
  input  logic               M_AXIS_ARESETN,
  input  logic [PHASE_W-1:0] frequency,
  input  logic [PHASE_W-1:0] amplitude,
  ramp_gen_if.master         m_axis
);

  logic [PHASE_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic [DATA_W-1:0]   samples;
  logic [SAMPLE_W-1:0] amp;
  logic                load;

  assign amp = sat16(amplitude);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [PHASE_W-1:0] phase;
    assign phase = acc_q + PHASE_W'(k) * frequency;

    ramp_lane u_lane (
      .phase_i  (phase),
      .amp_i    (amp),
      .sample_o (samples[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  assign load = !tvalid_q || m_axis.tready;

  always_comb begin
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (load) begin
      // Next beat's lane 0 follows this beat's lane 15.
      acc_d    = acc_q + (frequency << 4);
      tdata_d  = samples;
      tvalid_d = 1'b1;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tstrb  = '1;
  assign m_axis.tlast  = 1'b0;

endmodule

// File: tb/tb_ramp_gen.sv
// Directed bench for ramp_gen: reset, streaming, backpressure,
// frequency/amplitude changes and mid-stream reset.
module tb_ramp_gen;
  import ramp_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] freq;
  logic [31:0] amp;
  int          n_cmp;
  int          n_bad;

  ramp_gen_if axis ();

  ramp_gen dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .frequency      (freq),
    .amplitude      (amp),
    .m_axis         (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lane(input int k);
    logic signed [15:0] v;
    v = axis.tdata[16*k +: 16];
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_side(input string tag);
    chk({tag, "_tstrb"}, int'(axis.tstrb), int'(32'hFFFFFFFF));
    chk({tag, "_tlast"}, int'(axis.tlast), 0);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    freq        = 32'd52428800;
    amp         = 32'd7800;
    axis.tready = 1'b1;

    // Reset held two cycles
    step();
    step();
    chk("rst_valid", int'(axis.tvalid), 0);
    chk("rst_data0", int'(axis.tdata == '0), 1);
    chk_side("rst");

    // Release: first beat is acc = 0
    rst_n = 1'b1;
    step();
    chk("b1_valid", int'(axis.tvalid), 1);
    chk("b1_l0", lane(0), 0);
    chk("b1_l1", lane(1), 95);
    chk("b1_l15", lane(15), 1428);
    chk_side("b1");

    step();
    chk("b2_l0", lane(0), 1523);
    step();
    chk("b3_l0", lane(0), 3046);
    step();
    chk("b4_l0", lane(0), -3230);

    // Backpressure: three held cycles
    axis.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", int'(axis.tvalid), 1);
      chk("bp_l0", lane(0), -3230);
    end
    axis.tready = 1'b1;
    step();
    chk("b5_l0", lane(0), -1707);
    step();
    chk("b6_l0", lane(0), -183);
    step();
    chk("b7_l0_wrap", lane(0), 1340);

    // Mid-stream reset, one cycle
    rst_n = 1'b0;
    step();
    chk("mrst_valid", int'(axis.tvalid), 0);
    chk("mrst_data0", int'(axis.tdata == '0), 1);
    rst_n = 1'b1;
    step();
    chk("mr_valid", int'(axis.tvalid), 1);
    chk("mr_l0", lane(0), 0);
    chk("mr_l1", lane(1), 95);
    chk("mr_l15", lane(15), 1428);

    // Frequency change while held; acc is now 0x32000000
    axis.tready = 1'b0;
    step();
    freq = 32'h1000_0000;
    step();
    chk("fc_hold_l1", lane(1), 95);
    chk("fc_hold_l15", lane(15), 1428);
    axis.tready = 1'b1;
    step();
    chk("fc_l0", lane(0), 1523);
    chk("fc_l1", lane(1), 2010);

    // DC: frequency 0, acc stays 0x32000000
    freq = 32'd0;
    step();
    chk("dc_l0", lane(0), 1523);
    chk("dc_l15", lane(15), 1523);

    // Zero gain
    amp = 32'd0;
    step();
    chk("a0_l0", lane(0), 0);
    chk("a0_l7", lane(7), 0);

    // Saturated gain from acc = 0
    rst_n = 1'b0;
    amp   = 32'h0001_0000;
    freq  = 32'h1000_0000;
    step();
    rst_n = 1'b1;
    step();
    chk("sat_l1", lane(1), 4095);
    chk("sat_l8", lane(8), -32768);
    chk("sat_l15", lane(15), -4096);
    chk_side("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
